// File: rtl/riscv_pkg.sv
// Shared memory-stage definitions: access sizes, FSM states, funct3 field positions.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_pkg;

  // funct3[1:0] access size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // funct3 bit that selects zero-extension on loads
  localparam int F3_UNSIGNED = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } mem_state_t;

  // Legal when the size is defined and the byte offset is a multiple of it.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (offset[0] == 1'b0);
      SZ_W:    ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_avalon_if.sv
// Avalon-MM bus between the memory stage (master) and the data memory (slave).
// Latency: none (wires only).
// Backpressure: carried by avm_waitrequest; read data returns on avm_readdatavalid.
interface mem_stage_avalon_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: legality check, byte enables, store replication, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  reqSize,
  input  logic [1:0]  reqOffset,
  input  logic [31:0] reqData,
  output logic        reqAligned,
  output logic [3:0]  reqByteEn,
  output logic [31:0] reqWrData,
  input  logic [2:0]  ldFunct3,
  input  logic [1:0]  ldOffset,
  input  logic [31:0] ldRawData,
  output logic [31:0] ldData
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic        ldUns;

  // Request side: legality, active lanes and store data replicated onto every lane.
  always_comb begin
    reqAligned = isAligned(reqSize, reqOffset);
    reqByteEn  = 4'b0000;
    reqWrData  = reqData;
    case (reqSize)
      SZ_B: begin
        reqByteEn = 4'b0001 << reqOffset;
        reqWrData = {4{reqData[7:0]}};
      end
      SZ_H: begin
        reqByteEn = 4'b0011 << {reqOffset[1], 1'b0};
        reqWrData = {2{reqData[15:0]}};
      end
      SZ_W:    reqByteEn = 4'b1111;
      default: reqByteEn = 4'b0000;
    endcase
  end

  // Load side: pick the addressed byte/half from the word and sign- or zero-extend it.
  always_comb begin
    ldUns = ldFunct3[F3_UNSIGNED];
    case (ldOffset)
      2'd0:    ldByte = ldRawData[7:0];
      2'd1:    ldByte = ldRawData[15:8];
      2'd2:    ldByte = ldRawData[23:16];
      default: ldByte = ldRawData[31:24];
    endcase
    ldHalf = ldOffset[1] ? ldRawData[31:16] : ldRawData[15:0];
    case (ldFunct3[1:0])
      SZ_B:    ldData = ldUns ? {24'b0, ldByte} : {{24{ldByte[7]}}, ldByte};
      SZ_H:    ldData = ldUns ? {16'b0, ldHalf} : {{16{ldHalf[15]}}, ldHalf};
      default: ldData = ldRawData;
    endcase
  end

endmodule

// File: rtl/mem_stage_avalon.sv
// RISC-V MEM stage: issues one load/store per instruction as an Avalon-MM master.
// Latency: store 2 stall cycles, load 3 stall cycles with a zero-wait slave; DONE releases the pipe.
// Backpressure: holds bus signals while avm_waitrequest; stalls upstream until the access completes or times out.
module mem_stage_avalon
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                clr,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          funct3,
  input  logic [31:0]         AluRes,
  input  logic [31:0]         Reg2,
  mem_stage_avalon_if.master  avm,
  output logic                stall,
  output logic [31:0]         load_data,
  output logic                load_valid,
  output logic                misalign,
  output logic                bus_err
);

  // Counter wide enough to hold TIMEOUT-1; a zero TIMEOUT disables the abort path.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mem_state_t        state;
  logic [ADDR_W-1:0] addrQ;
  logic              rdQ;
  logic              wrQ;
  logic [31:0]       wdQ;
  logic [3:0]        beQ;
  logic [2:0]        f3Q;
  logic [1:0]        offQ;
  logic              flushQ;
  logic [TW-1:0]     tmoCnt;

  logic              req;
  logic              reqAligned;
  logic [3:0]        reqByteEn;
  logic [31:0]       reqWrData;
  logic [31:0]       ldData;
  logic              tmoHit;
  logic              ldCommit;

  mem_lane_align u_align (
    .reqSize    (funct3[1:0]),
    .reqOffset  (AluRes[1:0]),
    .reqData    (Reg2),
    .reqAligned (reqAligned),
    .reqByteEn  (reqByteEn),
    .reqWrData  (reqWrData),
    .ldFunct3   (f3Q),
    .ldOffset   (offQ),
    .ldRawData  (avm.avm_readdata),
    .ldData     (ldData)
  );

  assign avm.avm_address    = addrQ;
  assign avm.avm_read       = rdQ;
  assign avm.avm_write      = wrQ;
  assign avm.avm_writedata  = wdQ;
  assign avm.avm_byteenable = beQ;

  assign req    = MemRead | MemWrite;
  assign tmoHit = (TIMEOUT != 0) && (tmoCnt == TMO_LAST);

  // Read data lands either in the accept cycle of RD_REQ or later in RD_WAIT.
  assign ldCommit = avm.avm_readdatavalid &&
                    (((state == RD_REQ) && !avm.avm_waitrequest) || (state == RD_WAIT));

  // Stall starts combinationally on a legal request and covers every bus cycle; DONE releases it.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req & reqAligned & ~clr;
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  // Transaction FSM with registered bus signals, result pulses and the wait timeout.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      addrQ      <= '0;
      rdQ        <= 1'b0;
      wrQ        <= 1'b0;
      wdQ        <= '0;
      beQ        <= '0;
      f3Q        <= '0;
      offQ       <= '0;
      flushQ     <= 1'b0;
      tmoCnt     <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;

      // A flush anywhere in the transaction, including the data cycle, discards the load result.
      if (ldCommit && !(flushQ || clr)) begin
        load_data  <= ldData;
        load_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req && !clr) begin
            if (!reqAligned) begin
              misalign <= 1'b1;
            end else begin
              addrQ  <= {AluRes[ADDR_W-1:2], 2'b00};
              beQ    <= reqByteEn;
              wdQ    <= reqWrData;
              f3Q    <= funct3;
              offQ   <= AluRes[1:0];
              flushQ <= 1'b0;
              tmoCnt <= '0;
              // A simultaneous read and write request is treated as a store.
              if (MemWrite) begin
                wrQ   <= 1'b1;
                state <= WR_REQ;
              end else begin
                rdQ   <= 1'b1;
                state <= RD_REQ;
              end
            end
          end
        end

        WR_REQ: begin
          if (clr) flushQ <= 1'b1;
          if (!avm.avm_waitrequest) begin
            wrQ   <= 1'b0;
            state <= DONE;
          end else if (tmoHit) begin
            wrQ     <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end

        RD_REQ: begin
          if (clr) flushQ <= 1'b1;
          if (!avm.avm_waitrequest) begin
            rdQ    <= 1'b0;
            tmoCnt <= '0;
            state  <= avm.avm_readdatavalid ? DONE : RD_WAIT;
          end else if (tmoHit) begin
            rdQ     <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end

        RD_WAIT: begin
          if (clr) flushQ <= 1'b1;
          if (avm.avm_readdatavalid) begin
            state <= DONE;
          end else if (tmoHit) begin
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_avalon.sv
// Randomized scoreboard bench for mem_stage_avalon against a byte-addressed memory model.
// Latency: checks stall-cycle counts on directed accesses.
// Backpressure: slave model inserts waitrequest and variable read-data latency.
module tb_mem_stage_avalon;

  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_LD  = 2;
  localparam int EV_MIS = 3;
  localparam int EV_ERR = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b1;
  logic        clr = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] AluRes = 32'h0;
  logic [31:0] Reg2 = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;

  mem_stage_avalon_if #(.ADDR_W(32)) avm();

  mem_stage_avalon #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .clr        (clr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .AluRes     (AluRes),
    .Reg2       (Reg2),
    .avm        (avm),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  always #5 CLK = ~CLK;

  ev_t         expQ[$];
  int          nAssert = 0;
  int          nFail = 0;
  int          wrHigh = 0;
  logic [31:0] mmem[16];
  logic [31:0] smem[16];
  logic [31:0] lastLoad = 32'h0;

  int forceWait = 0;
  int fixLat = -1;
  bit randWait = 1'b0;
  bit noRdv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkReset(input string p);
    chk({p, "_read"},   {31'b0, avm.avm_read}, 32'h0);
    chk({p, "_write"},  {31'b0, avm.avm_write}, 32'h0);
    chk({p, "_addr"},   avm.avm_address, 32'h0);
    chk({p, "_wdata"},  avm.avm_writedata, 32'h0);
    chk({p, "_be"},     {28'b0, avm.avm_byteenable}, 32'h0);
    chk({p, "_ldata"},  load_data, 32'h0);
    chk({p, "_lvalid"}, {31'b0, load_valid}, 32'h0);
    chk({p, "_misal"},  {31'b0, misalign}, 32'h0);
    chk({p, "_buserr"}, {31'b0, bus_err}, 32'h0);
    chk({p, "_stall"},  {31'b0, stall}, 32'h0);
  endtask

  // Reference model: what the memory system should observe for one instruction.
  task automatic expectInstr(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input int clrAt, input bit expErr);
    int n, off, sz, idx;
    logic [31:0] w, v, mask, lane;
    ev_t e;
    if (!(rd || wr) || clrAt == 0) return;
    sz  = int'(f3[1:0]);
    off = int'(a % 4);
    idx = int'((a / 4) % 16);
    if (sz == 3 || (off % (1 << sz)) != 0) begin
      e = '{EV_MIS, 32'h0, 4'h0, 32'h0};
      expQ.push_back(e);
      return;
    end
    n = 1 << sz;
    e.addr = a & ~32'h3;
    e.be   = 4'(((1 << n) - 1) << off);
    if (wr) begin
      w = 32'h0;
      for (int i = 0; i < 4; i++) w |= ((d >> (8 * (i % n))) & 32'hFF) << (8 * i);
      for (int i = 0; i < 4; i++) if (e.be[i]) begin
        lane = 32'hFF << (8 * i);
        mmem[idx] = (mmem[idx] & ~lane) | (w & lane);
      end
      e.kind = EV_WR;
      e.data = w;
      expQ.push_back(e);
      return;
    end
    e.kind = EV_RD;
    e.data = 32'h0;
    expQ.push_back(e);
    if (expErr) begin
      e = '{EV_ERR, 32'h0, 4'h0, 32'h0};
      expQ.push_back(e);
    end else if (clrAt < 0) begin
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
      v = (mmem[idx] >> (8 * off)) & mask;
      if (!f3[2] && n < 4 && v[8 * n - 1]) v |= ~mask;
      e = '{EV_LD, 32'h0, 4'h0, v};
      expQ.push_back(e);
    end
  endtask

  // Present one instruction until the pipeline advances (an edge with stall low).
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int clrAt, input bit expErr, output int nStall);
    int cyc;
    bit s;
    MemRead  = rd;
    MemWrite = wr;
    funct3   = f3;
    AluRes   = a;
    Reg2     = d;
    expectInstr(rd, wr, f3, a, d, clrAt, expErr);
    nStall = 0;
    cyc = 0;
    do begin
      clr = (cyc == clrAt);
      @(negedge CLK);
      s = stall;
      if (s) nStall++;
      @(posedge CLK);
      #1;
      cyc++;
    end while (s && cyc < 100);
    if (cyc >= 100) begin
      nAssert++;
      nFail++;
      $display("FAIL stall_timeout: stall still 1 after %0d cycles, required release", cyc);
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic popChk(input int kind, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    ev_t e;
    if (expQ.size() == 0) begin
      nAssert++;
      nFail++;
      $display("FAIL unexpected_event: got kind %0d, required no event", kind);
      return;
    end
    e = expQ.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind != e.kind) return;
    case (kind)
      EV_WR: begin
        chk("wr_addr", a, e.addr);
        chk("wr_be", {28'b0, b}, {28'b0, e.be});
        chk("wr_data", d, e.data);
      end
      EV_RD: begin
        chk("rd_addr", a, e.addr);
        chk("rd_be", {28'b0, b}, {28'b0, e.be});
      end
      EV_LD: begin
        chk("load_data", d, e.data);
        lastLoad = e.data;
      end
      default: ;
    endcase
  endtask

  // Avalon slave model: waitrequest insertion, variable read latency, byte-enabled writes.
  initial begin
    int pendCnt, pendIdx, consec, lat, idx;
    pendCnt = 0; pendIdx = 0; consec = 0;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata      = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = $urandom;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          avm.avm_readdatavalid = 1'b1;
          avm.avm_readdata      = smem[pendIdx];
        end
      end
      if ((avm.avm_read || avm.avm_write) && forceWait > 0) begin
        avm.avm_waitrequest = 1'b1;
        forceWait--;
      end else if (randWait && consec < 2 && $urandom_range(0, 2) == 0) begin
        avm.avm_waitrequest = 1'b1;
      end else begin
        avm.avm_waitrequest = 1'b0;
      end
      consec = avm.avm_waitrequest ? consec + 1 : 0;
      idx = int'(avm.avm_address[5:2]);
      if (avm.avm_read && !avm.avm_waitrequest && !noRdv) begin
        lat = (fixLat >= 0) ? fixLat : int'($urandom_range(0, 2));
        if (lat == 0) begin
          avm.avm_readdatavalid = 1'b1;
          avm.avm_readdata      = smem[idx];
        end else begin
          pendCnt = lat;
          pendIdx = idx;
        end
      end
      if (avm.avm_write && !avm.avm_waitrequest)
        for (int i = 0; i < 4; i++)
          if (avm.avm_byteenable[i]) smem[idx][8*i +: 8] = avm.avm_writedata[8*i +: 8];
    end
  end

  // Monitor: pops the scoreboard on every observable result and checks hold-stability.
  initial begin
    bit hold;
    logic [31:0] pA, pD;
    logic [3:0] pB;
    logic pR, pW;
    hold = 1'b0;
    pA = 0; pD = 0; pB = 0; pR = 0; pW = 0;
    forever begin
      @(negedge CLK);
      if (!RST_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_addr", avm.avm_address, pA);
          chk("hold_be", {28'b0, avm.avm_byteenable}, {28'b0, pB});
          chk("hold_wdata", avm.avm_writedata, pD);
          chk("hold_rw", {30'b0, avm.avm_read, avm.avm_write}, {30'b0, pR, pW});
        end
        hold = (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
        pA = avm.avm_address; pB = avm.avm_byteenable; pD = avm.avm_writedata;
        pR = avm.avm_read; pW = avm.avm_write;
        if (avm.avm_write) wrHigh++;
        if (avm.avm_write && !avm.avm_waitrequest)
          popChk(EV_WR, avm.avm_address, avm.avm_byteenable, avm.avm_writedata);
        if (avm.avm_read && !avm.avm_waitrequest)
          popChk(EV_RD, avm.avm_address, avm.avm_byteenable, 32'h0);
        if (load_valid) popChk(EV_LD, 32'h0, 4'h0, load_data);
        if (misalign)   popChk(EV_MIS, 32'h0, 4'h0, 32'h0);
        if (bus_err)    popChk(EV_ERR, 32'h0, 4'h0, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // Directed scenarios first, then a randomized instruction stream.
  initial begin
    int ns;
    ev_t e;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = $urandom;
      smem[i] = mmem[i];
    end
    #2 RST_n = 1'b0;
    @(posedge CLK);
    #1;
    chkReset("reset");
    @(posedge CLK);
    #1 RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // Word store, zero-wait slave
    wrHigh = 0;
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, -1, 1'b0, ns);
    chk("sw_stall_cycles", ns, 2);
    chk("sw_write_cycles", wrHigh, 1);

    // Byte loads from the top lane, signed then unsigned
    mmem[0] = 32'h8012_3456;
    smem[0] = 32'h8012_3456;
    fixLat = 1;
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, -1, 1'b0, ns);
    chk("lb_stall_cycles", ns, 3);
    chk("lb_sign_ext", load_data, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, -1, 1'b0, ns);
    chk("lbu_zero_ext", load_data, 32'h0000_0080);
    fixLat = -1;

    // Half store held off by three waitrequest cycles
    forceWait = 3;
    wrHigh = 0;
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hCAFE_1234, -1, 1'b0, ns);
    chk("sh_write_cycles", wrHigh, 4);
    chk("sh_stall_cycles", ns, 5);

    // Misaligned word load
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, -1, 1'b0, ns);
    chk("misalign_stall_cycles", ns, 0);
    @(posedge CLK);
    #1;

    // Read data never returns
    noRdv = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, -1, 1'b1, ns);
    chk("tmo_stall_cycles", ns, 6);
    chk("tmo_read_low", {31'b0, avm.avm_read}, 32'h0);
    chk("tmo_load_kept", load_data, lastLoad);
    noRdv = 1'b0;

    // Flush while waiting for read data
    mmem[2] = 32'h1234_5678;
    smem[2] = 32'h1234_5678;
    fixLat = 3;
    issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 2, 1'b0, ns);
    chk("clr_load_kept", load_data, lastLoad);

    // Reset while in RD_WAIT
    MemRead = 1'b1; funct3 = 3'b010; AluRes = 32'h104;
    e = '{EV_RD, 32'h104, 4'hF, 32'h0};
    expQ.push_back(e);
    @(posedge CLK);
    #1 MemRead = 1'b0;
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chkReset("midreset");
    lastLoad = 32'h0;
    @(posedge CLK);
    #1 RST_n = 1'b1;
    fixLat = -1;
    repeat (6) @(posedge CLK);
    #1;

    // Randomized instruction stream
    randWait = 1'b1;
    for (int k = 0; k < 250; k++) begin
      bit rd, wr;
      int sz, ca;
      logic [2:0] f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      rd = !wr || ($urandom_range(0, 3) == 0);
      sz = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      f3 = {(!wr && $urandom_range(0, 1) == 1), 2'(sz)};
      a = 32'h100 + $urandom_range(0, 63);
      if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 1);
      ca = ($urandom_range(0, 9) == 0) ? 0 : -1;
      issue(rd, wr, f3, a, $urandom, ca, 1'b0, ns);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
    randWait = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("scoreboard_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
